thor2023_region_table_loader: RTL and testbench



---
 rtl/thor2023_region_table_loader_if.sv | 14 +
 rtl/thor2023_region_table_loader.sv | 251 +++++++++++++++++++++++++
 tb/tb_thor2023_region_table_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thor2023_region_table_loader_if.sv
// Request bus between the region-table loader (master) and the region-table responder (slave).
interface thor2023_region_table_loader_if;
   logic         cyc;
   logic         stb;
   logic         we;
   logic [15:0]  sel;
   logic [31:0]  padr;
   logic [127:0] dato;
   logic         ack;
   logic [127:0] dati;

   modport master (output cyc, stb, we, sel, padr, dato, input ack, dati);
   modport slave  (input cyc, stb, we, sel, padr, dato, output ack, dati);
endinterface

// File: rtl/thor2023_region_table_loader.sv
// Walks the region (PMA) table after reset or on start: unlock, write pmt/cta/at, relock each entry.
// Optional readback check of every non-unlock write is enabled by THOR2023_RGN_READBACK_VERIFY_EN.
module thor2023_region_table_loader #(
   parameter logic [31:0] RGN_BASE   = 32'hFEEF0000,
   parameter int          NREGIONS   = 8,
   parameter int          TMO_CYCLES = 255,
   parameter bit          AUTO_START = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic [4:0]                     tbl_adr,
   input  logic [127:0]                   tbl_dat,
   thor2023_region_table_loader_if.master bus,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [2:0]                     err_rgn,
   output logic [1:0]                     err_code
);
   localparam logic [127:0]  UNLK     = 128'h554E4C4B;
   localparam logic [127:0]  LOCK     = 128'h4C4F434B;
   localparam logic [2:0]    LAST_RGN = 3'(NREGIONS - 1);
   localparam int            TW       = $clog2(TMO_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

`ifdef THOR2023_RGN_READBACK_VERIFY_EN
   typedef enum logic [3:0] {IDLE, FETCH, FWAIT, WRITE, WACK, VRD, VACK, NEXT, DONE, FAIL} state_t;
`else
   typedef enum logic [3:0] {IDLE, FETCH, FWAIT, WRITE, WACK, NEXT, DONE, FAIL} state_t;
`endif

   state_t         state_q, state_d;
   logic           first_q;
   logic [2:0]     rgn_q, rgn_d;
   logic [2:0]     step_q, step_d;
   logic [127:0]   data_q, data_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [4:0]     tbl_adr_q, tbl_adr_d;
   logic           cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [15:0]    sel_q, sel_d;
   logic [31:0]    padr_q, padr_d;
   logic [127:0]   dato_q, dato_d;
   logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [2:0]     err_rgn_q, err_rgn_d;
   logic [1:0]     err_code_q, err_code_d;

   logic           fetch_step;
   logic           tmo_expired;
   logic [1:0]     sel_idx;
   logic [31:0]    entry_adr;

   // Steps 1..3 come from the init table; steps 0 and 4 target the lock word (sel 3).
   assign fetch_step  = (step_q != 3'd0) && (step_q != 3'd4);
   assign sel_idx     = fetch_step ? (step_q[1:0] - 2'd1) : 2'd3;
   assign entry_adr   = RGN_BASE | {23'd0, rgn_q, sel_idx, 4'h0};
   assign tmo_expired = (tmo_q == TMO_LAST);

`ifdef THOR2023_RGN_READBACK_VERIFY_EN
   logic [127:0] rb_mask;
   logic         rb_mismatch;
   // pmt and cta only hold 48 meaningful bits.
   assign rb_mask     = (step_q == 3'd1 || step_q == 3'd2) ? {80'h0, {48{1'b1}}} : {128{1'b1}};
   assign rb_mismatch = ((bus.dati ^ data_q) & rb_mask) != 128'h0;
`else
   logic unused_dati;
   assign unused_dati = ^bus.dati;
`endif

   always_comb begin
      state_d    = state_q;
      rgn_d      = rgn_q;
      step_d     = step_q;
      data_d     = data_q;
      tmo_d      = tmo_q;
      tbl_adr_d  = tbl_adr_q;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      sel_d      = sel_q;
      padr_d     = padr_q;
      dato_d     = dato_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      err_rgn_d  = err_rgn_q;
      err_code_d = err_code_q;
      case (state_q)
         IDLE: if (start || first_q) begin
            busy_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            err_code_d = 2'd0;
            rgn_d      = 3'd0;
            step_d     = 3'd0;
            state_d    = FETCH;
         end
         FETCH: if (fetch_step) begin
            state_d = FWAIT;
         end else begin
            data_d  = (step_q == 3'd0) ? UNLK : LOCK;
            state_d = WRITE;
         end
         FWAIT: begin
            data_d  = tbl_dat;
            state_d = WRITE;
         end
         WRITE: begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            sel_d   = 16'hFFFF;
            padr_d  = entry_adr;
            dato_d  = data_q;
            tmo_d   = '0;
            state_d = WACK;
         end
         WACK: begin
            if (bus.ack) begin
               cyc_d = 1'b0;
               stb_d = 1'b0;
               we_d  = 1'b0;
`ifdef THOR2023_RGN_READBACK_VERIFY_EN
               state_d = (step_q == 3'd0) ? NEXT : VRD;
`else
               state_d = NEXT;
`endif
            end else if (tmo_expired) begin
               cyc_d      = 1'b0;
               stb_d      = 1'b0;
               we_d       = 1'b0;
               err_code_d = 2'd1;
               state_d    = FAIL;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
`ifdef THOR2023_RGN_READBACK_VERIFY_EN
         VRD: begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b0;
            tmo_d   = '0;
            state_d = VACK;
         end
         VACK: begin
            if (bus.ack) begin
               cyc_d = 1'b0;
               stb_d = 1'b0;
               if (rb_mismatch) begin
                  err_code_d = 2'd2;
                  state_d    = FAIL;
               end else begin
                  state_d = NEXT;
               end
            end else if (tmo_expired) begin
               cyc_d      = 1'b0;
               stb_d      = 1'b0;
               err_code_d = 2'd1;
               state_d    = FAIL;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
`endif
         NEXT: begin
            if (step_q == 3'd4) begin
               if (rgn_q == LAST_RGN) begin
                  state_d = DONE;
               end else begin
                  rgn_d   = rgn_q + 3'd1;
                  step_d  = 3'd0;
                  state_d = FETCH;
               end
            end else begin
               step_d = step_q + 3'd1;
               // Present the table address now so data is ready when FWAIT latches it.
               if (step_q != 3'd3) tbl_adr_d = {rgn_q, step_q[1:0]};
               state_d = FETCH;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         FAIL: begin
            busy_d    = 1'b0;
            err_d     = 1'b1;
            err_rgn_d = rgn_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         first_q    <= AUTO_START;
         rgn_q      <= 3'd0;
         step_q     <= 3'd0;
         data_q     <= '0;
         tmo_q      <= '0;
         tbl_adr_q  <= 5'd0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         sel_q      <= 16'h0;
         padr_q     <= 32'h0;
         dato_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_rgn_q  <= 3'd0;
         err_code_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         first_q    <= 1'b0;
         rgn_q      <= rgn_d;
         step_q     <= step_d;
         data_q     <= data_d;
         tmo_q      <= tmo_d;
         tbl_adr_q  <= tbl_adr_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         sel_q      <= sel_d;
         padr_q     <= padr_d;
         dato_q     <= dato_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_rgn_q  <= err_rgn_d;
         err_code_q <= err_code_d;
      end
   end

   assign tbl_adr  = tbl_adr_q;
   assign bus.cyc  = cyc_q;
   assign bus.stb  = stb_q;
   assign bus.we   = we_q;
   assign bus.sel  = sel_q;
   assign bus.padr = padr_q;
   assign bus.dato = dato_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_rgn  = err_rgn_q;
   assign err_code = err_code_q;
endmodule

// File: tb/tb_thor2023_region_table_loader.sv
// Bench for thor2023_region_table_loader: responder + init-table models and a transaction-list reference.
module tb_thor2023_region_table_loader;
   localparam logic [31:0]  BASE = 32'hFEEF0000;
   localparam logic [127:0] UNLK = 128'h554E4C4B;
   localparam logic [127:0] LOCK = 128'h4C4F434B;
`ifdef THOR2023_RGN_READBACK_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int NTX = VERIFY ? 72 : 40;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [4:0]   tbl_adr;
   logic [127:0] tbl_dat = '0;
   logic         busy, done, err;
   logic [2:0]   err_rgn;
   logic [1:0]   err_code;

   thor2023_region_table_loader_if bus();

   thor2023_region_table_loader dut (
      .clk(clk), .rst(rst), .start(start), .tbl_adr(tbl_adr), .tbl_dat(tbl_dat), .bus(bus),
      .busy(busy), .done(done), .err(err), .err_rgn(err_rgn), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [127:0] tbl_mem  [32];
   logic [127:0] resp_mem [32];
   int           ack_delay = 0;
   bit           block_en = 1'b0;
   logic [31:0]  block_adr = '0;
   bit           corrupt_en = 1'b0;
   logic [31:0]  corrupt_adr = '0;
   int           wait_cnt = 0;
   int           n_wr = 0;
   int           n_rd = 0;
   logic [31:0]  act_padr [$];
   logic [127:0] act_dato [$];

   logic         exp_we   [NTX];
   logic [31:0]  exp_padr [NTX];
   logic [127:0] exp_dato [NTX];
   int           exp_idx = 0;
   bit           chk_en = 1'b0;
   bit           prev_ack = 1'b0;

   task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Synchronous init table: data follows the address by one clock.
   always @(posedge clk) tbl_dat <= tbl_mem[tbl_adr];

   // Responder: acks after ack_delay waiting cycles; remembers writes for readback.
   always @(posedge clk) begin
      if (rst) begin
         bus.ack  <= 1'b0;
         bus.dati <= '0;
         wait_cnt = 0;
      end else begin
         bus.ack <= 1'b0;
         if (bus.cyc && bus.stb && !bus.ack) begin
            if (wait_cnt >= ack_delay && !(block_en && bus.padr == block_adr)) begin
               bus.ack <= 1'b1;
               wait_cnt = 0;
               if (bus.we) begin
                  resp_mem[bus.padr[8:4]] = bus.dato;
                  n_wr++;
                  act_padr.push_back(bus.padr);
                  act_dato.push_back(bus.dato);
               end else begin
                  bus.dati <= (corrupt_en && bus.padr == corrupt_adr) ? 128'h0 : resp_mem[bus.padr[8:4]];
                  n_rd++;
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Every cycle with a bus cycle open: it must be the next transaction of the reference list.
   always @(negedge clk) begin
      if (rst) begin
         prev_ack = 1'b0;
      end else if (chk_en) begin
         if (prev_ack) chk("idle_gap_cyc", 192'(bus.cyc), 192'(1'b0));
         if (bus.cyc) begin
            if (exp_idx >= NTX) begin
               total++;
               bad++;
               $display("FAIL extra_txn: got index %0d required below %0d", exp_idx, NTX);
            end else begin
               chk("bus_txn", {busy, bus.stb, bus.we, bus.we ? bus.sel : 16'h0, bus.padr, bus.we ? bus.dato : 128'h0},
                   {1'b1, 1'b1, exp_we[exp_idx], exp_we[exp_idx] ? 16'hFFFF : 16'h0, exp_padr[exp_idx],
                    exp_we[exp_idx] ? exp_dato[exp_idx] : 128'h0});
            end
            if (bus.ack) exp_idx++;
         end
         prev_ack = bus.cyc && bus.ack;
      end
   end

   function automatic logic [191:0] out_vec();
      return {bus.cyc, bus.stb, bus.we, bus.sel, bus.padr, bus.dato, tbl_adr, busy, done, err, err_rgn, err_code};
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(string name, int limit);
      int c = 0;
      while (busy && c < limit) begin
         @(negedge clk);
         c++;
      end
      total++;
      if (busy) begin
         bad++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, limit);
      end
   endtask

   initial begin
      int k;
      int b;
      int br;
      int c;
      int stuck;
      logic [31:0] adr;
      for (int i = 0; i < 32; i++)
         tbl_mem[i] = {32'hA5A50000 | 32'(i), 32'h12340000 + 32'(i * 7), 32'hC3C30000 ^ 32'(i), 32'h00010000 * 32'(i + 1)};
      tbl_mem[4] = 128'h2400;
      // Reference: 5 writes per region in region order, each non-unlock write optionally read back.
      k = 0;
      for (int r = 0; r < 8; r++) begin
         for (int s = 0; s < 5; s++) begin
            adr = BASE | 32'(r * 64) | 32'(((s == 0 || s == 4) ? 3 : s - 1) * 16);
            exp_we[k]   = 1'b1;
            exp_padr[k] = adr;
            exp_dato[k] = (s == 0) ? UNLK : (s == 4) ? LOCK : tbl_mem[r * 4 + s - 1];
            k++;
            if (VERIFY && s != 0) begin
               exp_we[k]   = 1'b0;
               exp_padr[k] = adr;
               exp_dato[k] = exp_dato[k - 1];
               k++;
            end
         end
      end

      // Reset state, then auto start with a coincident start pulse: one load only.
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_values", out_vec(), 192'h0);
      b = n_wr;
      exp_idx = 0;
      rst = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("auto_busy_done", {busy, done}, 2'b10);
      wait_idle("auto_load", 3000);
      chk("auto_flags", {done, err, busy}, 3'b100);
      chk("auto_writes", n_wr - b, 40);
      chk("auto_txn_count", exp_idx, NTX);
      chk("r1_unlk_adr", act_padr[b + 5], 32'hFEEF0070);
      chk("r1_unlk_dat", act_dato[b + 5], 128'h554E4C4B);
      chk("r1_pmt_adr", act_padr[b + 6], 32'hFEEF0040);
      chk("r1_pmt_dat", act_dato[b + 6], 128'h2400);
      chk("r1_cta_adr", act_padr[b + 7], 32'hFEEF0050);
      chk("r1_at_adr", act_padr[b + 8], 32'hFEEF0060);
      chk("r1_lock", {act_padr[b + 9], act_dato[b + 9]}, {32'hFEEF0070, 128'h4C4F434B});
      $display("load 1 (auto): writes=%0d done=%0d", n_wr - b, done);

      // Slow responder: signals must hold through every WACK.
      ack_delay = 10;
      exp_idx = 0;
      b = n_wr;
      pulse_start();
      chk("slow_busy_done", {busy, done}, 2'b10);
      wait_idle("slow_load", 6000);
      chk("slow_flags", {done, err}, 2'b10);
      chk("slow_writes", n_wr - b, 40);
      $display("load 2 (ack delay 10): writes=%0d done=%0d", n_wr - b, done);

      // start while busy in region 2 is ignored.
      ack_delay = 1;
      exp_idx = 0;
      b = n_wr;
      pulse_start();
      c = 0;
      while (n_wr - b < 11 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      pulse_start();
      chk("restart_still_busy", busy, 1'b1);
      wait_idle("restart_load", 3000);
      chk("restart_writes", n_wr - b, 40);
      chk("restart_txn_count", exp_idx, NTX);
      chk("restart_done", done, 1'b1);
      $display("load 3 (start while busy): writes=%0d done=%0d", n_wr - b, done);

      // No ack on region 3 pmt: timeout after 255 cycles.
      ack_delay = 0;
      block_en = 1'b1;
      block_adr = 32'hFEEF00C0;
      exp_idx = 0;
      b = n_wr;
      pulse_start();
      stuck = 0;
      c = 0;
      while (busy && c < 3000) begin
         if (bus.cyc && bus.padr == block_adr) stuck++;
         @(negedge clk);
         c++;
      end
      chk("tmo_cycles", stuck, 255);
      chk("tmo_flags", {err, done, busy, bus.cyc}, 4'b1000);
      chk("tmo_err_rgn", err_rgn, 3'd3);
      chk("tmo_err_code", err_code, 2'd1);
      chk("tmo_writes", n_wr - b, 16);
      block_en = 1'b0;
      $display("load 4 (no ack): err=%0d err_rgn=%0d err_code=%0d held=%0d", err, err_rgn, err_code, stuck);

      // Reset during region 5 WACK, then a fresh auto load.
      ack_delay = 2;
      exp_idx = 0;
      pulse_start();
      c = 0;
      while (!(bus.cyc && bus.padr[8:6] == 3'd5) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk("rgn5_reached", {bus.cyc, bus.padr[8:6]}, 4'b1101);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_reset_values", out_vec(), 192'h0);
      exp_idx = 0;
      b = n_wr;
      rst = 1'b0;
      @(negedge clk);
      chk("reauto_busy", busy, 1'b1);
      wait_idle("reauto_load", 3000);
      chk("reauto_writes", n_wr - b, 40);
      chk("reauto_first_adr", act_padr[b], 32'hFEEF0030);
      chk("reauto_done", {done, err}, 2'b10);
      $display("load 5 (reset mid-load, auto restart): writes=%0d done=%0d", n_wr - b, done);

`ifdef THOR2023_RGN_READBACK_VERIFY_EN
      // Responder loses region 4 at: readback mismatch.
      ack_delay = 0;
      corrupt_en = 1'b1;
      corrupt_adr = 32'hFEEF0120;
      exp_idx = 0;
      pulse_start();
      wait_idle("rb_fail_load", 3000);
      chk("rb_fail_flags", {err, done}, 2'b10);
      chk("rb_fail_code", err_code, 2'd2);
      chk("rb_fail_rgn", err_rgn, 3'd4);
      corrupt_en = 1'b0;
      $display("load 6 (readback mismatch): err=%0d err_rgn=%0d err_code=%0d", err, err_rgn, err_code);
      exp_idx = 0;
      b = n_wr;
      br = n_rd;
      pulse_start();
      wait_idle("rb_ok_load", 3000);
      chk("rb_ok_counts", {32'(n_wr - b), 32'(n_rd - br)}, {32'd40, 32'd32});
      chk("rb_ok_done", {done, err}, 2'b10);
      $display("load 7 (readback ok): writes=%0d reads=%0d done=%0d", n_wr - b, n_rd - br, done);
`else
      br = n_rd;
      chk("no_reads", br, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
